// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_pkg
// Purpose  : Shared definitions for the stack sequencer: default geometry and
//            the 4-bit FSM state encoding used by stack_sequencer.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package stack_pkg;

  localparam int STACK_DATA_W = 16;
  localparam int STACK_DEPTH  = 16;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_PUSH   = 4'd1;
  localparam logic [3:0] ST_POP_RD = 4'd2;
  localparam logic [3:0] ST_POP_WB = 4'd3;
  localparam logic [3:0] ST_CLR    = 4'd4;

  typedef enum logic [3:0] {
    IDLE   = ST_IDLE,
    PUSH   = ST_PUSH,
    POP_RD = ST_POP_RD,
    POP_WB = ST_POP_WB,
    CLR    = ST_CLR
  } state_t;

endpackage
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem
// Purpose  : DEPTH x DATA_W register array backing the stack. One synchronous
//            write port, one combinational read port. Contents are not reset.
// Ports    : clk   - clock
//            we    - write enable
//            waddr - write index
//            wdata - write data
//            raddr - read index
//            rdata - combinational read data
// Revision : 1.0 - initial release
// ============================================================================
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_sequencer
// Purpose  : Request-driven LIFO stack. A small FSM accepts one push, pop or
//            clear at a time from IDLE (priority clear > pop > push), pulses
//            ack once on completion and drops any request seen while busy.
//            Optional feature macro: STACK_SEQ_OVF_FLAG_EN adds the sticky
//            ovf_err output (set by push-while-full / pop-while-empty).
// Ports    : clk       - clock, rising edge
//            rst       - asynchronous active-low reset
//            push_req  - push request pulse (with push_data)
//            pop_req   - pop request pulse
//            clear     - empty-the-stack request pulse
//            push_data - entry to push
//            pop_data  - registered last popped entry
//            ack       - one-cycle completion pulse
//            busy      - FSM not in IDLE
//            empty     - depth == 0
//            full      - depth == DEPTH
//            depth     - current entry count
//            ovf_err   - sticky over/underflow flag (macro only)
// Revision : 1.0 - initial release
// ============================================================================
module stack_sequencer
  import stack_pkg::*;
#(
  parameter int DATA_W = STACK_DATA_W,
  parameter int DEPTH  = STACK_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_req,
  input  logic                     pop_req,
  input  logic                     clear,
  input  logic [DATA_W-1:0]        push_data,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     ack,
  output logic                     busy,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   depth
`ifdef STACK_SEQ_OVF_FLAG_EN
  ,
  output logic                     ovf_err
`endif
);

  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int DEPTH_W = ADDR_W + 1;
  localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);
  localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

  state_t              state_q, state_d;
  logic [DEPTH_W-1:0]  depth_q, depth_d;
  logic [DATA_W-1:0]   pop_data_q, pop_data_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [ADDR_W-1:0]   mem_raddr;
  logic [DATA_W-1:0]   mem_rdata;
`ifdef STACK_SEQ_OVF_FLAG_EN
  logic                ovf_q, ovf_d;
`endif

  assign empty    = (depth_q == '0);
  assign full     = (depth_q == DEPTH_MAX);
  assign depth    = depth_q;
  assign busy     = (state_q != IDLE);
  assign pop_data = pop_data_q;
`ifdef STACK_SEQ_OVF_FLAG_EN
  assign ovf_err  = ovf_q;
`endif

  // Top of stack lives at depth-1; when full the low bits of depth are zero
  // and the modular subtraction still lands on DEPTH-1.
  assign mem_waddr = depth_q[ADDR_W-1:0];
  assign mem_raddr = depth_q[ADDR_W-1:0] - ADDR_W'(1);

  stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (wr_data_q),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d    = state_q;
    depth_d    = depth_q;
    pop_data_d = pop_data_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;
    ack        = 1'b0;
`ifdef STACK_SEQ_OVF_FLAG_EN
    ovf_d      = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d = CLR;
        end else if (pop_req) begin
          state_d = POP_RD;
        end else if (push_req) begin
          state_d   = PUSH;
          wr_data_d = push_data;
        end
      end
      PUSH: begin
        ack     = 1'b1;
        state_d = IDLE;
        if (!full) begin
          mem_we  = 1'b1;
          depth_d = depth_q + DEPTH_ONE;
        end
`ifdef STACK_SEQ_OVF_FLAG_EN
        else begin
          ovf_d = 1'b1;
        end
`endif
      end
      POP_RD: begin
        state_d = POP_WB;
        if (!empty) begin
          pop_data_d = mem_rdata;
        end
`ifdef STACK_SEQ_OVF_FLAG_EN
        else begin
          ovf_d = 1'b1;
        end
`endif
      end
      POP_WB: begin
        ack     = 1'b1;
        state_d = IDLE;
        if (!empty) begin
          depth_d = depth_q - DEPTH_ONE;
        end
      end
      CLR: begin
        ack     = 1'b1;
        state_d = IDLE;
        depth_d = '0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      depth_q    <= '0;
      pop_data_q <= '0;
`ifdef STACK_SEQ_OVF_FLAG_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      depth_q    <= depth_d;
      pop_data_q <= pop_data_d;
`ifdef STACK_SEQ_OVF_FLAG_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  // Holding register for the pushed entry needs no reset: it is only
  // written to storage after being loaded on an accepted push.
  always_ff @(posedge clk) begin
    wr_data_q <= wr_data_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_sequencer
// Purpose  : Scoreboard bench for stack_sequencer. Stimulus tasks queue the
//            expected ack (cycle, depth during ack, pop_data) for each
//            accepted request; a negedge monitor pops and compares on ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stack_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        push_req = 1'b0;
  logic        pop_req = 1'b0;
  logic        clear = 1'b0;
  logic [15:0] push_data = 16'h0;
  wire  [15:0] pop_data;
  wire         ack;
  wire         busy;
  wire         empty;
  wire         full;
  wire  [4:0]  depth;
`ifdef STACK_SEQ_OVF_FLAG_EN
  wire         ovf_err;
`endif

  stack_sequencer #(.DATA_W(16), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .push_req  (push_req),
    .pop_req   (pop_req),
    .clear     (clear),
    .push_data (push_data),
    .pop_data  (pop_data),
    .ack       (ack),
    .busy      (busy),
    .empty     (empty),
    .full      (full),
    .depth     (depth)
`ifdef STACK_SEQ_OVF_FLAG_EN
    ,
    .ovf_err   (ovf_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int n_cmp  = 0;
  int n_fail = 0;
  int mdepth = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          exp_cyc;
    bit          chk_pd;
    logic [15:0] exp_pd;
    logic [4:0]  exp_depth;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_ack: got ack=1 at cycle %0d, required no ack", cyc);
      end else begin
        e_mon = sb.pop_front();
        check("ack_latency", cyc, e_mon.exp_cyc);
        check("ack_depth", {27'b0, depth}, {27'b0, e_mon.exp_depth});
        if (e_mon.chk_pd) check("pop_data", {16'b0, pop_data}, {16'b0, e_mon.exp_pd});
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle", {31'b0, busy}, 32'd0);
  endtask

  task automatic op_push(input logic [15:0] d);
    sb.push_back('{exp_cyc: cyc + 1, chk_pd: 1'b0, exp_pd: 16'h0, exp_depth: 5'(mdepth)});
    push_req  = 1'b1;
    push_data = d;
    @(negedge clk);
    push_req  = 1'b0;
    wait_idle();
    if (mdepth < 16) mdepth++;
  endtask

  task automatic op_pop(input logic [15:0] exp_pd);
    sb.push_back('{exp_cyc: cyc + 2, chk_pd: 1'b1, exp_pd: exp_pd, exp_depth: 5'(mdepth)});
    pop_req = 1'b1;
    @(negedge clk);
    pop_req = 1'b0;
    wait_idle();
    if (mdepth > 0) mdepth--;
  endtask

  task automatic op_clear();
    sb.push_back('{exp_cyc: cyc + 1, chk_pd: 1'b0, exp_pd: 16'h0, exp_depth: 5'(mdepth)});
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_idle();
    mdepth = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_depth", {27'b0, depth}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_pop_data", {16'b0, pop_data}, 32'd0);
`ifdef STACK_SEQ_OVF_FLAG_EN
    check("rst_ovf", {31'b0, ovf_err}, 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Basic push / pop
    op_push(16'h00A1);
    op_push(16'h00B2);
    op_push(16'h00C3);
    check("depth_after_3push", {27'b0, depth}, 32'd3);
    check("empty_after_3push", {31'b0, empty}, 32'd0);
    op_pop(16'h00C3);
    op_pop(16'h00B2);
    check("depth_after_2pop", {27'b0, depth}, 32'd1);

    // Fill, push-while-full, pop top
    op_clear();
    for (int i = 0; i < 16; i++) op_push(16'h1000 + 16'(i));
    check("full_flag", {31'b0, full}, 32'd1);
    check("depth_full", {27'b0, depth}, 32'd16);
    op_push(16'hFFFF);
    check("depth_push_full", {27'b0, depth}, 32'd16);
`ifdef STACK_SEQ_OVF_FLAG_EN
    check("ovf_push_full", {31'b0, ovf_err}, 32'd1);
`endif
    op_pop(16'h100F);
    check("depth_after_full_pop", {27'b0, depth}, 32'd15);

    // Same-cycle clear/pop/push: clear wins
    op_clear();
    for (int i = 0; i < 5; i++) op_push(16'h2000 + 16'(i));
    check("depth_5", {27'b0, depth}, 32'd5);
    sb.push_back('{exp_cyc: cyc + 1, chk_pd: 1'b0, exp_pd: 16'h0, exp_depth: 5'(mdepth)});
    clear = 1'b1; pop_req = 1'b1; push_req = 1'b1; push_data = 16'hBEEF;
    @(negedge clk);
    clear = 1'b0; pop_req = 1'b0; push_req = 1'b0;
    wait_idle();
    mdepth = 0;
    check("depth_after_triple", {27'b0, depth}, 32'd0);
    check("pop_data_after_triple", {16'b0, pop_data}, 32'h100F);

    // Push pulsed during POP_RD is dropped
    for (int i = 0; i < 3; i++) op_push(16'h3000 + 16'(i));
    sb.push_back('{exp_cyc: cyc + 2, chk_pd: 1'b1, exp_pd: 16'h3002, exp_depth: 5'(mdepth)});
    pop_req = 1'b1;
    @(negedge clk);
    pop_req = 1'b0; push_req = 1'b1; push_data = 16'hDEAD;
    @(negedge clk);
    push_req = 1'b0;
    wait_idle();
    mdepth = 2;
    check("depth_drop_push", {27'b0, depth}, 32'd2);
    op_pop(16'h3001);

    // Reset during POP_RD
    op_clear();
    for (int i = 0; i < 4; i++) op_push(16'h4000 + 16'(i));
    pop_req = 1'b1;
    @(negedge clk);
    pop_req = 1'b0;
    check("in_pop_rd_busy", {31'b0, busy}, 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_depth", {27'b0, depth}, 32'd0);
    check("midrst_pop_data", {16'b0, pop_data}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ack", {31'b0, ack}, 32'd0);
    mdepth = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    op_push(16'h1234);
    op_pop(16'h1234);

    // Pop while empty: pop_data and depth unchanged
    op_pop(16'h1234);
    check("depth_pop_empty", {27'b0, depth}, 32'd0);
`ifdef STACK_SEQ_OVF_FLAG_EN
    check("ovf_pop_empty", {31'b0, ovf_err}, 32'd1);
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
